// File: rtl/dm_pkg.sv
// dm_pkg: shared types and elaboration-time helpers for the data memory with
// built-in clear sweep.
//   dm_state_t : sweep sequencer state encoding
//   dm_depth   : number of words for a given address width
//   dm_lsb     : low bit index of port `port` in a packed bus of `width`-bit fields
package dm_pkg;

    typedef enum logic [1:0] {
        DM_IDLE  = 2'd0,
        DM_ARM   = 2'd1,
        DM_SWEEP = 2'd2
    } dm_state_t;

    function automatic int dm_depth(input int a);
        return 1 << a;
    endfunction

    function automatic int dm_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/dm_sweep_fsm.sv
// dm_sweep_fsm: clear-sweep sequencer. Walks a counter over every word of the
// array and issues one clear write per cycle while in DM_SWEEP.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   clear       : start-sweep request, honoured only in DM_IDLE
//   busy        : high while the state register holds DM_SWEEP
//   done        : one-cycle pulse registered on the edge of the last clear write
//   sweep_we    : clear write enable for this edge
//   sweep_addr  : clear write address for this edge
//   state       : current state, exported for observation and for the write gate
module dm_sweep_fsm
    import dm_pkg::*;
#(
    parameter int A            = 8,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    output logic         busy,
    output logic         done,
    output logic         sweep_we,
    output logic [A-1:0] sweep_addr,
    output dm_state_t    state
);

    localparam int        DEPTH = dm_depth(A);
    // Counter is one bit wider than the address; the terminal compare stops it
    // at DEPTH-1 so it never wraps into a second pass.
    localparam logic [A:0] LAST = (A+1)'(DEPTH - 1);
    localparam logic [A:0] ONE  = (A+1)'(1);
    localparam dm_state_t  RST_STATE = CLR_ON_RESET ? DM_ARM : DM_IDLE;

    dm_state_t  state_q, state_d;
    logic [A:0] cnt_q, cnt_d;
    logic       done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        sweep_we = 1'b0;
        case (state_q)
            DM_IDLE: begin
                if (clear) begin
                    state_d = DM_SWEEP;
                    cnt_d   = '0;
                end
            end
            // Reaching here means reset has been released for one edge.
            DM_ARM: begin
                state_d = DM_SWEEP;
                cnt_d   = '0;
            end
            // Clear is deliberately not looked at: no restart, no extension.
            DM_SWEEP: begin
                sweep_we = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DM_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = DM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign sweep_addr = cnt_q[A-1:0];
    assign busy       = (state_q == DM_SWEEP);
    assign done       = done_q;
    assign state      = state_q;

endmodule

// File: rtl/data_mem_sweep.sv
// data_mem_sweep: single-clock data memory with one write port, NRD registered
// read ports (latency 1, read-first) and a hardware clear sweep.
// Ports:
//   Clk, Reset_n : clock (rising edge), asynchronous active-low reset
//   Clear        : start-sweep request (ignored unless idle)
//   WrEn/WrAddr/WrData : external write port, accepted only when idle and Clear=0
//   RdAddr       : packed read addresses, port i = [i*A +: A]
//   RdData       : packed registered read data, port i = [i*W +: W]
//   Busy         : sweep in progress
//   Done         : one-cycle pulse after the last sweep write
//   Dropped      : one-cycle pulse after an external write was rejected
// NRD is intended to be 1..4.
module data_mem_sweep
    import dm_pkg::*;
#(
    parameter int             W            = 8,
    parameter int             A            = 8,
    parameter int             NRD          = 2,
    parameter logic [W-1:0]   CLR_VAL      = '0,
    parameter bit             CLR_ON_RESET = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             WrEn,
    input  logic [A-1:0]     WrAddr,
    input  logic [W-1:0]     WrData,
    input  logic [NRD*A-1:0] RdAddr,
    output logic [NRD*W-1:0] RdData,
    output logic             Busy,
    output logic             Done,
    output logic             Dropped
);

    localparam int DEPTH = dm_depth(A);

    logic         sweep_we;
    logic [A-1:0] sweep_addr;
    dm_state_t    fsm_state;
    logic         ext_accept;

    dm_sweep_fsm #(
        .A            (A),
        .CLR_ON_RESET (CLR_ON_RESET)
    ) u_fsm (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .clear      (Clear),
        .busy       (Busy),
        .done       (Done),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .state      (fsm_state)
    );

    // Clear wins over a coincident write: the same edge starts the sweep.
    assign ext_accept = WrEn && (fsm_state == DM_IDLE) && !Clear;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Dropped <= 1'b0;
        end else begin
            Dropped <= WrEn && !ext_accept;
        end
    end

    // Array contents survive reset. Sweep and external writes are mutually
    // exclusive by construction; the sweep is given priority anyway.
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= CLR_VAL;
        end else if (ext_accept) begin
            mem[WrAddr] <= WrData;
        end
    end

    // Non-blocking array update gives read-first: a same-edge write to the
    // addressed word shows up one cycle later.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [A-1:0] addr;
        logic [W-1:0] data_q;

        assign addr = RdAddr[dm_lsb(i, A) +: A];

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                data_q <= '0;
            end else begin
                data_q <= mem[addr];
            end
        end

        assign RdData[dm_lsb(i, W) +: W] = data_q;
    end

endmodule
